// File: rtl/led_blink_pkg.sv
// led_blink_pkg
// Shared types and helpers for the LED/heartbeat generator bank.
//   mode_t        : per-channel display mode (OFF / ON / BLINK / FLASH)
//   chan_ctl_t    : width-independent part of a channel's state
//   mode_running  : true for modes whose counter advances
//   led_decode    : LED level for a given mode and phase
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FLASH = 2'd3
    } mode_t;

    // Mode and phase carry no width parameter, so they can be shared here;
    // the full per-channel state (with cnt/half) lives in led_blink_chan.
    typedef struct packed {
        logic [1:0] phase;
        mode_t      mode;
    } chan_ctl_t;

    function automatic logic mode_running(input mode_t m);
        return (m == MODE_BLINK) || (m == MODE_FLASH);
    endfunction

    // BLINK is high on even phases; FLASH only on phase 0 (1 of 4 half-periods).
    function automatic logic led_decode(input mode_t m, input logic [1:0] ph);
        logic v;
        case (m)
            MODE_OFF:   v = 1'b0;
            MODE_ON:    v = 1'b1;
            MODE_BLINK: v = ~ph[0];
            MODE_FLASH: v = (ph == 2'd0);
            default:    v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan
// One LED/heartbeat channel: half-period counter, 2-bit phase and LED decode.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   load         : take load_mode / load_half, restart counter at phase 0
//   load_mode    : new display mode
//   load_half    : new half-period in cycles (0 behaves as 1)
//   sync         : restart phase of a running channel (ignored while loading)
//   led, tick    : registered LED level and half-period expiry pulse
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int    CNT_W        = 27,
    parameter int    DEFAULT_HALF = 50_000_000,
    parameter mode_t RST_MODE     = MODE_BLINK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  mode_t            load_mode,
    input  logic [CNT_W-1:0] load_half,
    input  logic             sync,
    output logic             led,
    output logic             tick
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        chan_ctl_t        ctl;
        logic [CNT_W-1:0] half;
    } chan_state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
    // Reset phase 01 keeps BLINK/FLASH dark until the first expiry.
    localparam chan_state_t RST_STATE = '{
        cnt:  ZERO,
        ctl:  '{phase: 2'b01, mode: RST_MODE},
        half: RST_HALF
    };

    chan_state_t st_q, st_d;
    logic        led_q, led_d;
    logic        tick_q, tick_d;

    // Next-state: load beats sync beats free-running count.
    always_comb begin
        st_d   = st_q;
        tick_d = 1'b0;
        if (load) begin
            st_d.ctl.mode  = load_mode;
            st_d.half      = (load_half == ZERO) ? ONE : load_half;
            st_d.cnt       = ZERO;
            st_d.ctl.phase = 2'd0;
        end else if (mode_running(st_q.ctl.mode)) begin
            if (sync) begin
                st_d.cnt       = ZERO;
                st_d.ctl.phase = 2'd0;
            end else if (st_q.cnt == st_q.half - ONE) begin
                // half is never 0, so half-1 cannot underflow and cnt < half holds.
                st_d.cnt       = ZERO;
                st_d.ctl.phase = st_q.ctl.phase + 2'd1;
                tick_d         = 1'b1;
            end else begin
                st_d.cnt = st_q.cnt + ONE;
            end
        end else begin
            st_d.cnt       = ZERO;
            st_d.ctl.phase = 2'd0;
        end
        // LED follows the next state so a load is visible at its own edge.
        led_d = led_decode(st_d.ctl.mode, st_d.ctl.phase);
    end

    // Channel state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= RST_STATE;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: rtl/led_blink_bank.sv
// led_blink_bank
// Bank of NCHAN independent LED/heartbeat generators with a valid/ready
// configuration port and a global phase resync.
// Ports:
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   cfg_valid/ready    : configuration handshake (accept = valid && ready)
//   cfg_chan           : target channel (out-of-range is accepted and dropped)
//   cfg_mode, cfg_half : new mode and half-period for the target channel
//   sync_pulse         : restart phase of every BLINK/FLASH channel
//   led, tick          : registered per-channel outputs
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int    NCHAN        = 8,
    parameter int    CNT_W        = 27,
    parameter int    DEFAULT_HALF = 50_000_000,
    parameter mode_t RST_MODE     = MODE_BLINK,
    localparam int   CHAN_W       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              sync_pulse,
    output logic [NCHAN-1:0]  led,
    output logic [NCHAN-1:0]  tick
);

    logic             cfg_ready_q, cfg_ready_d;
    logic             accept;
    logic [NCHAN-1:0] load_vec;

    // Handshake: ready drops for exactly the cycle after each accept.
    always_comb begin
        accept      = cfg_valid && cfg_ready_q;
        cfg_ready_d = ~accept;
    end

    // Ready register; low while in reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;

    // One-hot channel select; an out-of-range cfg_chan matches nothing.
    always_comb begin
        load_vec = {NCHAN{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            load_vec[i] = accept && (cfg_chan == CHAN_W'(i));
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        led_blink_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF),
            .RST_MODE     (RST_MODE)
        ) u_chan (
            .clk       (sys_clk),
            .rst_n     (sys_rst_n),
            .load      (load_vec[g]),
            .load_mode (mode_t'(cfg_mode)),
            .load_half (cfg_half),
            .sync      (sync_pulse),
            .led       (led[g]),
            .tick      (tick[g])
        );
    end

endmodule

// File: tb/tb_led_blink_bank.sv
module tb_led_blink_bank;
    import led_blink_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DH  = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_chan;
    logic [1:0]     cfg_mode;
    logic [CW-1:0]  cfg_half;
    logic           sync_pulse;
    logic [NCH-1:0] led;
    logic [NCH-1:0] tick;

    always #5 clk = ~clk;

    led_blink_bank #(
        .NCHAN        (NCH),
        .CNT_W        (CW),
        .DEFAULT_HALF (DH),
        .RST_MODE     (MODE_BLINK)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_half   (cfg_half),
        .sync_pulse (sync_pulse),
        .led        (led),
        .tick       (tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is described by elapsed cycles k since its
    // last restart and the phase p0 it restarted at; phase and LED follow arithmetically.
    int m_mode [NCH];
    int m_half [NCH];
    int m_k    [NCH];
    int m_p0   [NCH];
    bit m_ready;
    bit m_acc;

    function automatic logic m_led(input int ch);
        int ph;
        ph = (m_p0[ch] + m_k[ch] / m_half[ch]) % 4;
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (ph % 2) == 0;
            default: return ph == 0;
        endcase
    endfunction

    function automatic logic m_tick(input int ch);
        return (m_mode[ch] >= 2) && (m_k[ch] > 0) && ((m_k[ch] % m_half[ch]) == 0);
    endfunction

    function automatic logic [NCH-1:0] m_led_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_led(c);
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_tick_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_tick(c);
        return v;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 2; m_half[c] = DH; m_k[c] = 0; m_p0[c] = 1;
            end
            m_ready = 1'b0;
            m_acc   = 1'b0;
        end else begin
            m_acc = cfg_valid && m_ready;
            for (int c = 0; c < NCH; c++) begin
                if (m_acc && (int'(cfg_chan) == c)) begin
                    m_mode[c] = int'(cfg_mode);
                    m_half[c] = (cfg_half == 8'd0) ? 1 : int'(cfg_half);
                    m_k[c]    = 0;
                    m_p0[c]   = 0;
                end else if (m_mode[c] >= 2) begin
                    if (sync_pulse) begin
                        m_k[c] = 0; m_p0[c] = 0;
                    end else begin
                        m_k[c] = m_k[c] + 1;
                    end
                end
            end
            m_ready = !m_acc;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare every output shortly after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".led"},   32'(led),       32'(m_led_vec()));
        check({tag, ".tick"},  32'(tick),      32'(m_tick_vec()));
        check({tag, ".ready"}, 32'(cfg_ready), 32'(m_ready));
    endtask

    typedef struct {
        bit         rst_n;
        logic [3:0] led;
        logic [3:0] tick;
        bit         ready;
    } vec_t;

    vec_t tbl [13];

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_mode = 2'd0;
        cfg_half = 8'd0; sync_pulse = 1'b0;
        m_ready = 1'b0; m_acc = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2; m_half[c] = DH; m_k[c] = 0; m_p0[c] = 1;
        end

        // Reset then release: LEDs rise after the 5th edge, fall after the 10th.
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 4'h0, 4'h0, 1'b1};
        tbl[3]  = '{1'b1, 4'h0, 4'h0, 1'b1};
        tbl[4]  = '{1'b1, 4'h0, 4'h0, 1'b1};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 1'b1};
        tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1};
        tbl[7]  = '{1'b1, 4'hF, 4'h0, 1'b1};
        tbl[8]  = '{1'b1, 4'hF, 4'h0, 1'b1};
        tbl[9]  = '{1'b1, 4'hF, 4'h0, 1'b1};
        tbl[10] = '{1'b1, 4'hF, 4'h0, 1'b1};
        tbl[11] = '{1'b1, 4'h0, 4'hF, 1'b1};
        tbl[12] = '{1'b1, 4'h0, 4'h0, 1'b1};
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            step("t1");
            check("t1.tbl_led",   32'(led),       32'(tbl[i].led));
            check("t1.tbl_tick",  32'(tick),      32'(tbl[i].tick));
            check("t1.tbl_ready", 32'(cfg_ready), 32'(tbl[i].ready));
        end

        // ch2 ON, then ch0 OFF held through the not-ready cycle.
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'd1; cfg_half = 8'd9;
        step("t2a");
        check("t2.led2_on", 32'(led[2]), 32'd1);
        check("t2.ready_lo", 32'(cfg_ready), 32'd0);
        cfg_chan = 2'd0; cfg_mode = 2'd0; cfg_half = 8'd5;
        step("t2b");
        check("t2.ready_back", 32'(cfg_ready), 32'd1);
        step("t2c");
        check("t2.led0_off", 32'(led[0]), 32'd0);
        check("t2.ready_lo2", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step("t2d");
            check("t2.led2_hold", 32'(led[2]), 32'd1);
            check("t2.tick2_lo", 32'(tick[2]), 32'd0);
        end

        // ch1 BLINK with half=0 behaves as half=1.
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_mode = 2'd2; cfg_half = 8'd0;
        step("t3a");
        cfg_valid = 1'b0;
        check("t3.led1_acc", 32'(led[1]), 32'd1);
        check("t3.tick1_acc", 32'(tick[1]), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            step("t3b");
            check("t3.led1", 32'(led[1]), 32'((j % 2) == 0));
            check("t3.tick1", 32'(tick[1]), 32'd1);
        end

        // ch3 FLASH half=3: high 3, low 9, tick every 3.
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_mode = 2'd3; cfg_half = 8'd3;
        step("t4a");
        cfg_valid = 1'b0;
        check("t4.led3_acc", 32'(led[3]), 32'd1);
        for (int j = 1; j <= 24; j++) begin
            step("t4b");
            check("t4.led3", 32'(led[3]), 32'(((j / 3) % 4) == 0));
            check("t4.tick3", 32'(tick[3]), 32'((j % 3) == 0));
        end

        // ch0 BLINK half=3 run to phase 1 / cnt 2, then sync plus cfg ch1 FLASH.
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_mode = 2'd2; cfg_half = 8'd3;
        step("t5a");
        cfg_valid = 1'b0;
        for (int j = 0; j < 5; j++) step("t5b");
        check("t5.led0_pre", 32'(led[0]), 32'd0);
        sync_pulse = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_mode = 2'd3; cfg_half = 8'd4;
        step("t5c");
        sync_pulse = 1'b0; cfg_valid = 1'b0;
        check("t5.led0_sync", 32'(led[0]), 32'd1);
        check("t5.led2_on", 32'(led[2]), 32'd1);
        check("t5.led1_cfg", 32'(led[1]), 32'd1);
        step("t5d");
        step("t5e");
        check("t5.led0_hold", 32'(led[0]), 32'd1);
        step("t5f");
        check("t5.led0_flip", 32'(led[0]), 32'd0);
        check("t5.tick0", 32'(tick[0]), 32'd1);

        // Reset during a pending configuration.
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'd0; cfg_half = 8'd1;
        rst_n = 1'b0;
        step("t6a");
        check("t6.led_rst", 32'(led), 32'd0);
        check("t6.tick_rst", 32'(tick), 32'd0);
        check("t6.ready_rst", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1; cfg_valid = 1'b0;
        step("t6b");
        check("t6.ready_up", 32'(cfg_ready), 32'd1);
        for (int j = 0; j < 4; j++) step("t6c");
        check("t6.led_blink", 32'(led), 32'hF);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if (!cfg_valid && ($urandom_range(0, 3) == 0)) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'($urandom_range(0, 3));
                cfg_mode  = 2'($urandom_range(0, 3));
                cfg_half  = 8'($urandom_range(0, 7));
            end
            rst_n      = ($urandom_range(0, 99) != 0);
            sync_pulse = ($urandom_range(0, 15) == 0);
            step("rnd");
            if (m_acc) cfg_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
